fabric_boot_ctrl: RTL and testbench
===================================

FABRIC_BOOT_CTRL -- requirements
Module: fabric_boot_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SLOT_WORDS, 4096: 32-bit words per bitstream slot, minimum 2.
- NUM_SLOTS, 16: valid slots, 1..16.
- BASE_ADDR, 24'h000000: byte address of slot 0.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- boot_i, in, 1: boot request, level-sampled in IDLE only.
- slot_i, in, 4: slot to load, sampled with boot_i.
- cfg_busy_i, in, 1: busy_o of fabric_config.
- mem_req_o, out, 1: memory read request.
- mem_gnt_i, in, 1: request accepted.
- mem_addr_o, out, 24: byte address.
- mem_rvalid_i, in, 1: read data valid.
- mem_rdata_i, in, 32: read data.
- bitstream_data_o, out, 32: word to fabric_config.
- bitstream_valid_o, out, 1: single-cycle word strobe.
- busy_o, out, 1: load in progress.
- done_o, out, 1: one-cycle completion pulse.
- error_o, out, 1: sticky error flag.

Function
REQ-003 FSM SHALL have states IDLE, FETCH, WAIT, PUSH, DRAIN, DONE; all outputs SHALL be registered.
REQ-004 IDLE: boot_i=1 with slot_i<NUM_SLOTS SHALL latch the slot, clear error_o and the word index, and enter FETCH next cycle.
REQ-005 IDLE: boot_i=1 with slot_i>=NUM_SLOTS SHALL set error_o, issue no memory request, and stay in IDLE.
REQ-006 mem_addr_o SHALL equal BASE_ADDR + slot*SLOT_WORDS*4 + idx*4, computed modulo 2^24 (wrap-around allowed, no saturation).
REQ-007 FETCH: mem_req_o SHALL stay 1 with a stable address until a cycle with mem_gnt_i=1, then drop and enter WAIT.
REQ-008 Only one request SHALL ever be outstanding.
REQ-009 WAIT: a cycle with mem_rvalid_i=1 SHALL capture mem_rdata_i and enter PUSH.
REQ-010 PUSH: bitstream_valid_o SHALL be 1 for exactly this one cycle, carrying the captured word.
REQ-011 After PUSH, the block SHALL enter FETCH with idx+1, or DRAIN after the last word.
REQ-012 Word latency: gnt-to-rvalid delay plus 1 cycle from rvalid to bitstream_valid_o.
REQ-013 DRAIN SHALL wait until cfg_busy_i=0, then enter DONE. DRAIN SHALL be entered no earlier than the cycle after the last PUSH.
REQ-014 DONE SHALL pulse done_o for one cycle and return to IDLE.
REQ-015 busy_o SHALL be 1 in every state except IDLE.
REQ-016 boot_i asserted while busy_o=1 SHALL be ignored and SHALL NOT be queued.
REQ-017 mem_rvalid_i outside WAIT SHALL be ignored.
REQ-018 mem_gnt_i and mem_rvalid_i asserted in the same cycle SHALL move FETCH to WAIT only; the rvalid SHALL NOT be consumed.

Reset
REQ-019 rst_ni=0 SHALL asynchronously force IDLE and set all outputs and internal registers to 0, including error_o and bitstream_data_o.
REQ-020 Reset asserted mid-load SHALL abort the load. No further bitstream_valid_o or mem_req_o SHALL occur until a new boot_i after reset release.

Configuration
REQ-021 Macro FABRIC_BOOT_CHECKSUM_EN defined:
- The last word of each slot is a checksum and SHALL NOT be forwarded; SLOT_WORDS-1 words are pushed.
- The checksum word SHALL be compared with the XOR of the pushed words.
- A mismatch SHALL set error_o in DRAIN; done_o SHALL still pulse.
REQ-022 Macro undefined: all SLOT_WORDS words SHALL be pushed, no checksum logic SHALL exist, and error_o SHALL be set only per REQ-005.

Verification
REQ-023 Benches SHALL use SLOT_WORDS=4, NUM_SLOTS=4, BASE_ADDR=24'h000100 and cover:
- Scenario 1: boot_i pulse, slot_i=2, memory with gnt and rvalid each 1 cycle later returning 0x11,0x22,0x33,0x44 -> addresses 0x120,0x124,0x128,0x12C; four single-cycle bitstream_valid_o with those data (three without the 0x44 when FABRIC_BOOT_CHECKSUM_EN); done_o one pulse; busy_o low afterwards.
- Scenario 2: slot_i=5 -> error_o=1, mem_req_o never asserted, busy_o stays 0; a later valid boot clears error_o.
- Scenario 3: mem_gnt_i held low for 10 cycles -> mem_req_o and mem_addr_o stable for all 10 cycles; no bitstream_valid_o.
- Scenario 4: rst_ni pulsed low after the second pushed word -> all outputs 0 immediately; no further activity without a new boot_i.
- Scenario 5: cfg_busy_i held high for 5 cycles after the last word -> done_o delayed until the cycle after cfg_busy_i falls; boot_i pulses during the load are ignored.
- Scenario 6 (FABRIC_BOOT_CHECKSUM_EN): words 0x1,0x2,0x4 with checksum 0x7 -> error_o=0; checksum 0x6 -> error_o=1 and done_o still pulses.

Source files
------------

// File: rtl/fabric_boot_ctrl.sv
// Boot loader: reads a bitstream slot word by word over a single-outstanding memory
// port and forwards each word to fabric_config. Optional checksum: FABRIC_BOOT_CHECKSUM_EN.
module fabric_boot_ctrl #(
  parameter int          SLOT_WORDS = 4096,
  parameter int          NUM_SLOTS  = 16,
  parameter logic [23:0] BASE_ADDR  = 24'h000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        boot_i,
  input  logic [3:0]  slot_i,
  input  logic        cfg_busy_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [23:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] bitstream_data_o,
  output logic        bitstream_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int               IDX_W       = (SLOT_WORDS > 1) ? $clog2(SLOT_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(SLOT_WORDS - 1);
  localparam logic [4:0]       NUM_SLOTS_W = 5'(NUM_SLOTS);
  localparam logic [23:0]      SLOT_BYTES  = 24'(SLOT_WORDS * 4);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PUSH, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [23:0]      base_reg, base_next;
  logic [23:0]      addr_reg, addr_next;
  logic [31:0]      data_reg, data_next;
  logic             req_reg, req_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;
  logic [23:0]      boot_base;
`ifdef FABRIC_BOOT_CHECKSUM_EN
  logic [31:0]      csum_reg, csum_next;
`endif

  // Slot base wraps modulo 2^24 by construction of the 24-bit arithmetic.
  assign boot_base = BASE_ADDR + 24'(slot_i) * SLOT_BYTES;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    base_next  = base_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    error_next = error_reg;
`ifdef FABRIC_BOOT_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (boot_i) begin
          if ({1'b0, slot_i} < NUM_SLOTS_W) begin
            state_next = FETCH;
            idx_next   = '0;
            base_next  = boot_base;
            addr_next  = boot_base;
            error_next = 1'b0;
`ifdef FABRIC_BOOT_CHECKSUM_EN
            csum_next  = '0;
`endif
          end else begin
            error_next = 1'b1;
          end
        end
      end
      FETCH: begin
        // A same-cycle rvalid belongs to nobody yet; only the grant is taken here.
        if (mem_gnt_i) state_next = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
`ifdef FABRIC_BOOT_CHECKSUM_EN
          if (idx_reg == LAST_IDX) begin
            state_next = DRAIN;
            if (mem_rdata_i != csum_reg) error_next = 1'b1;
          end else begin
            state_next = PUSH;
            data_next  = mem_rdata_i;
            csum_next  = csum_reg ^ mem_rdata_i;
          end
`else
          state_next = PUSH;
          data_next  = mem_rdata_i;
`endif
        end
      end
      PUSH: begin
`ifdef FABRIC_BOOT_CHECKSUM_EN
        // The checksum word is always still to come after any pushed word.
        state_next = FETCH;
        idx_next   = idx_reg + IDX_W'(1);
        addr_next  = base_reg + 24'({idx_next, 2'b00});
`else
        if (idx_reg == LAST_IDX) begin
          state_next = DRAIN;
        end else begin
          state_next = FETCH;
          idx_next   = idx_reg + IDX_W'(1);
          addr_next  = base_reg + 24'({idx_next, 2'b00});
        end
`endif
      end
      DRAIN: begin
        if (!cfg_busy_i) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered decodes of the next state.
    req_next   = (state_next == FETCH);
    valid_next = (state_next == PUSH);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      base_reg  <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
`ifdef FABRIC_BOOT_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      base_reg  <= base_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      req_reg   <= req_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      error_reg <= error_next;
`ifdef FABRIC_BOOT_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  assign mem_req_o         = req_reg;
  assign mem_addr_o        = addr_reg;
  assign bitstream_data_o  = data_reg;
  assign bitstream_valid_o = valid_reg;
  assign busy_o            = busy_reg;
  assign done_o            = done_reg;
  assign error_o           = error_reg;

endmodule

// File: tb/tb_fabric_boot_ctrl.sv
// Directed bench for fabric_boot_ctrl: cycle table for boot/error/stall paths,
// hand sequences for reset abort, drain back-pressure and checksum.
module tb_fabric_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot;
  logic [3:0]  slot;
  logic        cfg_busy;
  logic        req;
  logic        gnt;
  logic [23:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] bs_data;
  logic        bs_valid;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  fabric_boot_ctrl #(
    .SLOT_WORDS(4),
    .NUM_SLOTS (4),
    .BASE_ADDR (24'h000100)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .boot_i           (boot),
    .slot_i           (slot),
    .cfg_busy_i       (cfg_busy),
    .mem_req_o        (req),
    .mem_gnt_i        (gnt),
    .mem_addr_o       (addr),
    .mem_rvalid_i     (rvalid),
    .mem_rdata_i      (rdata),
    .bitstream_data_o (bs_data),
    .bitstream_valid_o(bs_valid),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error)
  );

  always #5 clk = ~clk;

`ifdef FABRIC_BOOT_CHECKSUM_EN
  localparam int          NPUSH   = 3;
  localparam logic [31:0] S1_LAST = 32'h33;
`else
  localparam int          NPUSH   = 4;
  localparam logic [31:0] S1_LAST = 32'h44;
`endif

  typedef struct {
    logic        boot;
    logic [3:0]  slot;
    logic        cfgb;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic b, input logic [3:0] s, input logic cb, input logic g,
                              input logic rv, input logic [31:0] rd, input logic rq,
                              input logic [23:0] a, input logic v, input logic [31:0] d,
                              input logic bz, input logic dn, input logic er);
    vec_t t;
    t.boot = b; t.slot = s; t.cfgb = cb; t.gnt = g; t.rv = rv; t.rdata = rd;
    t.exp  = {3'b000, rq, a, v, d, bz, dn, er};
    vecs.push_back(t);
  endfunction

  function automatic logic [63:0] obs();
    return {3'b000, req, addr, bs_valid, bs_data, busy, done, error};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full load with a memory that grants and returns data one cycle apart.
  task automatic run_load(input string tag, input logic [3:0] s, input logic [3:0][31:0] words,
                          input int hold, input logic exp_err);
    logic [23:0] base;
    base     = 24'h000100 + 24'(s) * 24'd16;
    cfg_busy = (hold > 0);
    boot = 1'b1; slot = s; tick(); boot = 1'b0;
    check({tag, "_start"}, {req, addr, busy}, {1'b1, base, 1'b1});
    for (int w = 0; w < 4; w++) begin
      gnt = 1'b1; boot = 1'b1; slot = 4'd0; tick(); gnt = 1'b0; boot = 1'b0;
      check($sformatf("%s_w%0d_wait", tag, w), {req, bs_valid, busy}, 3'b001);
      rvalid = 1'b1; rdata = words[w]; tick(); rvalid = 1'b0;
      if (w < NPUSH) begin
        check($sformatf("%s_w%0d_push", tag, w), {bs_valid, bs_data}, {1'b1, words[w]});
        tick();
        if (w + 1 < 4)
          check($sformatf("%s_w%0d_next", tag, w), {req, addr, bs_valid}, {1'b1, base + 24'(4 * (w + 1)), 1'b0});
        else
          check({tag, "_drain"}, {req, bs_valid, busy, done, error}, {4'b0010, exp_err});
      end else begin
        check({tag, "_drain"}, {req, bs_valid, busy, done, error}, {4'b0010, exp_err});
      end
    end
    for (int c = 0; c < hold; c++) begin
      boot = 1'b1; tick(); boot = 1'b0;
      check($sformatf("%s_hold%0d", tag, c), {busy, done}, 2'b10);
    end
    cfg_busy = 1'b0; tick();
    check({tag, "_done"}, {busy, done, error}, {2'b11, exp_err});
    tick();
    check({tag, "_idle"}, {req, busy, done, error}, {3'b000, exp_err});
    tick();
    check({tag, "_noqueue"}, {req, busy}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b1; boot = 1'b0; slot = 4'd0; cfg_busy = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    #2 rst_n = 1'b0;
    #1 check("reset_state", obs(), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Scenario 1: slot 2, gnt and rvalid each one cycle later.
    add(1, 2, 0, 0, 0, 0,     1, 24'h120, 0, 0,     1, 0, 0);
    add(0, 0, 0, 1, 0, 0,     0, 24'h120, 0, 0,     1, 0, 0);
    add(0, 0, 0, 0, 1, 'h11,  0, 24'h120, 1, 'h11,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0,     1, 24'h124, 0, 'h11,  1, 0, 0);
    add(0, 0, 0, 1, 0, 0,     0, 24'h124, 0, 'h11,  1, 0, 0);
    add(0, 0, 0, 0, 1, 'h22,  0, 24'h124, 1, 'h22,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0,     1, 24'h128, 0, 'h22,  1, 0, 0);
    add(0, 0, 0, 1, 0, 0,     0, 24'h128, 0, 'h22,  1, 0, 0);
    add(0, 0, 0, 0, 1, 'h33,  0, 24'h128, 1, 'h33,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0,     1, 24'h12C, 0, 'h33,  1, 0, 0);
    add(0, 0, 0, 1, 0, 0,     0, 24'h12C, 0, 'h33,  1, 0, 0);
`ifdef FABRIC_BOOT_CHECKSUM_EN
    add(0, 0, 0, 0, 1, 'h00,  0, 24'h12C, 0, 'h33,  1, 0, 0);
`else
    add(0, 0, 0, 0, 1, 'h44,  0, 24'h12C, 1, 'h44,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0,     0, 24'h12C, 0, 'h44,  1, 0, 0);
`endif
    add(0, 0, 0, 0, 0, 0,     0, 24'h12C, 0, S1_LAST, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,     0, 24'h12C, 0, S1_LAST, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,     0, 24'h12C, 0, S1_LAST, 0, 0, 0);
    // Scenario 2: out-of-range slot, then a valid boot clears the error.
    add(1, 5, 0, 0, 0, 0,     0, 24'h12C, 0, S1_LAST, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,     0, 24'h12C, 0, S1_LAST, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0,     1, 24'h110, 0, S1_LAST, 1, 0, 0);
    // Scenario 3: grant withheld for 10 cycles; stray rvalid ignored.
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 0, 1'(i % 2), 'hBAD, 1, 24'h110, 0, S1_LAST, 1, 0, 0);
    // gnt with same-cycle rvalid: that rvalid is not consumed.
    add(0, 0, 0, 1, 1, 'hDEAD, 0, 24'h110, 0, S1_LAST, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,      0, 24'h110, 0, S1_LAST, 1, 0, 0);
    add(0, 0, 0, 0, 1, 'h55,   0, 24'h110, 1, 'h55,    1, 0, 0);
    add(0, 0, 0, 0, 0, 0,      1, 24'h114, 0, 'h55,    1, 0, 0);
    add(0, 0, 0, 1, 0, 0,      0, 24'h114, 0, 'h55,    1, 0, 0);
    add(0, 0, 0, 0, 1, 'h66,   0, 24'h114, 1, 'h66,    1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      boot = vecs[i].boot; slot = vecs[i].slot; cfg_busy = vecs[i].cfgb;
      gnt = vecs[i].gnt; rvalid = vecs[i].rv; rdata = vecs[i].rdata;
      tick();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Scenario 4: reset right after the second pushed word.
    #2 rst_n = 1'b0;
    #1 check("s4_reset_now", obs(), 64'd0);
    boot = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      gnt = c[0]; rvalid = ~c[0]; rdata = 32'hF00 + 32'(c);
      tick();
      check($sformatf("s4_quiet%0d", c), {req, bs_valid, busy, done}, 4'b0000);
    end
    gnt = 1'b0; rvalid = 1'b0;

    // Scenario 5: back-pressure in drain, boot pokes ignored.
    run_load("s5", 4'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 5, 1'b0);

`ifdef FABRIC_BOOT_CHECKSUM_EN
    // Scenario 6: checksum match and mismatch.
    run_load("s6_good", 4'd0, {32'h7, 32'h4, 32'h2, 32'h1}, 0, 1'b0);
    run_load("s6_bad",  4'd1, {32'h6, 32'h4, 32'h2, 32'h1}, 0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
